prover_round_check: RTL

PROVER_ROUND_CHECK -- requirements
Module: prover_round_check

---
 rtl/prover_round_check.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/prover_round_check.sv
// Sumcheck round verifier. It checks H(0)+H(1) against the running claim, then
// evaluates H(tau) with Horner's rule to form the next claim. Field: Mersenne prime 2^61-1.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module prover_round_check #(
  parameter int nRounds = 9,
  parameter int mulLat  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               restart,
  input  logic [`F_NBITS-1:0]                claim_in,
  input  logic                               en,
  input  logic [3:0][`F_NBITS-1:0]           coeff_in,
  input  logic                               cubic,
  input  logic [`F_NBITS-1:0]                tau,
  output logic                               ready,
  output logic [`F_NBITS-1:0]                claim_out,
  output logic                               sum_ok,
  output logic                               err,
  output logic [$clog2(nRounds+1)-1:0]       round_cnt,
  output logic                               done
);

  // state | meaning
  // IDLE  | waiting for en; ready=1
  // CHECK | compare H(0)+H(1) with claim_out, seed Horner accumulator
  // MUL   | acc*tau in flight for mulLat cycles
  // ADD   | add next lower coefficient
  // FIN   | publish H(tau) as new claim, advance round count
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int N  = `F_NBITS;
  localparam int RW = $clog2(nRounds + 1);
  localparam logic [N-1:0]  Q         = `F_Q;
  localparam logic [RW-1:0] LAST      = RW'(nRounds);
  localparam logic [2:0]    TMR_START = 3'(mulLat - 1);

  function automatic logic [N-1:0] f_red(input logic [N-1:0] x);
    return (x >= Q) ? x - Q : x;
  endfunction

  function automatic logic [N-1:0] f_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[N-1:0];
  endfunction

  // 2^61 == 1 mod Q, so the high half of the product folds onto the low half.
  function automatic logic [N-1:0] f_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    logic [N:0]     s;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    s = {1'b0, p[N-1:0]} + {1'b0, p[2*N-1:N]};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[N-1:0];
  endfunction

  logic [2:0]          state;
  logic [3:0][N-1:0]   c_q;
  logic                cubic_q;
  logic [N-1:0]        tau_q;
  logic [N-1:0]        acc;
  logic [1:0]          idx;
  logic [2:0]          tmr;
  logic [mulLat-1:0][N-1:0] mul_pipe;
  logic [N-1:0]        sum_c;
  logic [RW-1:0]       cnt_nxt;

  assign ready   = (state == S_IDLE);
  assign cnt_nxt = round_cnt + 1'b1;

  always_comb begin
    sum_c = f_add(f_add(f_add(c_q[0], c_q[0]), c_q[1]),
                  f_add(c_q[2], cubic_q ? c_q[3] : '0));
  end

  // acc and tau_q are stable throughout MUL, so the last stage holds acc*tau after mulLat cycles.
  always_ff @(posedge clk) begin
    mul_pipe[0] <= f_mul(acc, tau_q);
    for (int i = 1; i < mulLat; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      claim_out <= '0;
      sum_ok    <= 1'b0;
      err       <= 1'b0;
      round_cnt <= '0;
      done      <= 1'b0;
      c_q       <= '0;
      cubic_q   <= 1'b0;
      tau_q     <= '0;
      acc       <= '0;
      idx       <= '0;
      tmr       <= '0;
    end else if (restart) begin
      state     <= S_IDLE;
      claim_out <= f_red(claim_in);
      sum_ok    <= 1'b0;
      err       <= 1'b0;
      round_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && round_cnt != LAST) begin
            for (int i = 0; i < 4; i++) c_q[i] <= f_red(coeff_in[i]);
            cubic_q <= cubic;
            tau_q   <= f_red(tau);
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          sum_ok <= (sum_c == claim_out);
          if (sum_c != claim_out) err <= 1'b1;
          acc   <= cubic_q ? c_q[3] : c_q[2];
          idx   <= cubic_q ? 2'd2 : 2'd1;
          tmr   <= TMR_START;
          state <= S_MUL;
        end
        S_MUL: begin
          if (tmr == 3'd0) state <= S_ADD;
          else tmr <= tmr - 3'd1;
        end
        S_ADD: begin
          acc <= f_add(mul_pipe[mulLat-1], c_q[idx]);
          if (idx == 2'd0) begin
            state <= S_FIN;
          end else begin
            idx   <= idx - 2'd1;
            tmr   <= TMR_START;
            state <= S_MUL;
          end
        end
        S_FIN: begin
          claim_out <= acc;
          round_cnt <= cnt_nxt;
          if (cnt_nxt == LAST) done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
